// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive front end: line sync, bit-timing recovery, NRZI decode and unstuffing.
// Define USB_RX_STUFF_ERR_EN to report bit-stuff violations on stuff_err and abort the packet.

module usb_rx_bit_decoder #(
    parameter int SAMPLE_PT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    output logic d_orig,
    output logic shift_enable,
    output logic eop,
    output logic stuff_err
);

    localparam logic [2:0] SAMPLE_CNT = 3'(SAMPLE_PT);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EOP_WAIT
    } state_t;

    state_t     state;
    logic       dp_meta;
    logic       dm_meta;
    logic       dp_s;
    logic       dm_s;
    logic       dp_s_prev;
    logic [2:0] bit_cnt;
    logic [2:0] ones;
    logic       last_dp;

    logic       line_edge;
    logic       sample_pt;
    logic       line_se0;
    logic       line_j;
    logic       nrzi_bit;
    logic       stuff_bit;

    // Reset to the idle J level so that leaving reset on an idle bus produces no edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta   <= 1'b1;
            dm_meta   <= 1'b0;
            dp_s      <= 1'b1;
            dm_s      <= 1'b0;
            dp_s_prev <= 1'b1;
        end else begin
            dp_meta   <= d_plus;
            dm_meta   <= d_minus;
            dp_s      <= dp_meta;
            dm_s      <= dm_meta;
            dp_s_prev <= dp_s;
        end
    end

    assign line_edge = dp_s ^ dp_s_prev;
    assign sample_pt = (state != IDLE) && (bit_cnt == SAMPLE_CNT) && !line_edge;
    assign line_se0  = !dp_s && !dm_s;
    assign line_j    = dp_s && !dm_s;
    assign nrzi_bit  = ~(dp_s ^ last_dp);
    assign stuff_bit = (ones == 3'd6);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            ones         <= '0;
            last_dp      <= 1'b1;
            d_orig       <= 1'b1;
            shift_enable <= 1'b0;
            eop          <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_err    <= 1'b0;
`endif
        end else begin
            shift_enable <= 1'b0;
            eop          <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_err    <= 1'b0;
`endif
            // Every line transition realigns the timer so the sample lands mid-bit.
            if (state == IDLE || line_edge) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    last_dp <= 1'b1;
                    if (line_edge) begin
                        state <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (sample_pt) begin
                        if (line_se0) begin
                            eop   <= 1'b1;
                            ones  <= '0;
                            state <= EOP_WAIT;
                        end else begin
                            last_dp <= dp_s;
                            if (stuff_bit) begin
                                ones <= '0;
`ifdef USB_RX_STUFF_ERR_EN
                                if (nrzi_bit) begin
                                    stuff_err <= 1'b1;
                                    state     <= EOP_WAIT;
                                end
`endif
                            end else begin
                                shift_enable <= 1'b1;
                                d_orig       <= nrzi_bit;
                                ones         <= nrzi_bit ? ones + 3'd1 : 3'd0;
                            end
                        end
                    end
                end

                EOP_WAIT: begin
                    if (sample_pt) begin
                        last_dp <= dp_s;
                        if (line_j) begin
                            last_dp <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef USB_RX_STUFF_ERR_EN
    assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard bench for usb_rx_bit_decoder: NRZI/stuffing line encoder drives pins, decoded pulses are checked.

module tb_usb_rx_bit_decoder;

    logic clk = 1'b0;
    logic n_rst;
    logic d_plus;
    logic d_minus;
    logic d_orig;
    logic shift_enable;
    logic eop;
    logic stuff_err;

    usb_rx_bit_decoder #(.SAMPLE_PT(3)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .d_orig       (d_orig),
        .shift_enable (shift_enable),
        .eop          (eop),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic val;
        int   at;
    } pulse_t;

    int     cycle = 0;
    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int     obs_rd = 0;
    int     eop_count = 0;
    int     serr_count = 0;
    int     compared = 0;
    int     mismatched = 0;
    logic   cur_dp;
    int     tb_ones;

    always @(posedge clk) cycle <= cycle + 1;

    // Record every DUT pulse between active edges; the test tasks consume them in order.
    always @(negedge clk) begin
        pulse_t o;
        if (shift_enable === 1'b1) begin
            o.val = d_orig;
            o.at  = cycle;
            obs_q.push_back(o);
        end
        if (eop === 1'b1) eop_count++;
        if (stuff_err === 1'b1) serr_count++;
    end

    task automatic drive_line(input logic dp, input logic dm, input int len);
        d_plus  = dp;
        d_minus = dm;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int len);
        if (b == 1'b0) cur_dp = ~cur_dp;
        drive_line(cur_dp, ~cur_dp, len);
    endtask

    task automatic send_payload(input logic b, input int len, input int at);
        pulse_t e;
        e.val = b;
        e.at  = at;
        exp_q.push_back(e);
        send_bit(b, len);
        if (b) tb_ones++;
        else tb_ones = 0;
        if (tb_ones == 6) begin
            send_bit(1'b0, 8);
            tb_ones = 0;
        end
    endtask

    task automatic send_sync(input int len_even, input int len_odd, input logic timed);
        int t0;
        t0 = cycle;
        for (int i = 0; i < 8; i++) begin
            send_payload((i == 7), (i % 2 == 0) ? len_even : len_odd,
                         timed ? t0 + 7 + 8 * i : -1);
        end
    endtask

    task automatic send_eop();
        drive_line(1'b0, 1'b0, 16);
        cur_dp = 1'b1;
        drive_line(1'b1, 1'b0, 24);
        tb_ones = 0;
    endtask

    task automatic next_obs(output pulse_t o, output logic got);
        got = (obs_rd < obs_q.size());
        if (got) begin
            o = obs_q[obs_rd];
            obs_rd++;
        end else begin
            o.val = 1'bx;
            o.at  = -1;
        end
    endtask

    task automatic test_reset();
        n_rst   = 1'b0;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        cur_dp  = 1'b1;
        tb_ones = 0;
        repeat (3) @(negedge clk);
        compared++;
        if ({d_orig, shift_enable, eop, stuff_err} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b, expected 1000", {d_orig, shift_enable, eop, stuff_err});
        end
        n_rst = 1'b1;
        repeat (64) @(negedge clk);
        compared++;
        if (obs_q.size() != 0 || eop_count != 0 || serr_count != 0) begin
            mismatched++;
            $display("[TB] FAIL idle_pulses: got se=%0d eop=%0d err=%0d, expected 0/0/0",
                     obs_q.size(), eop_count, serr_count);
        end
        compared++;
        if (d_orig !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL idle_d_orig: got %b, expected 1", d_orig);
        end
    endtask

    task automatic test_sync();
        pulse_t e, o;
        logic   got;
        int     eop0;
        eop0 = eop_count;
        send_sync(8, 8, 1'b1);
        send_eop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(o, got);
            compared++;
            if (!got || o.val !== e.val) begin
                mismatched++;
                $display("[TB] FAIL sync_bit: got %b (present=%0b), expected %b", o.val, got, e.val);
            end
            compared++;
            if (o.at != e.at) begin
                mismatched++;
                $display("[TB] FAIL sync_timing: got cycle %0d, expected cycle %0d", o.at, e.at);
            end
        end
        compared++;
        if (obs_rd != obs_q.size()) begin
            mismatched++;
            $display("[TB] FAIL sync_extra: got %0d extra pulses, expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
        compared++;
        if (eop_count - eop0 != 1) begin
            mismatched++;
            $display("[TB] FAIL sync_eop: got %0d eop pulses, expected 1", eop_count - eop0);
        end
    endtask

    task automatic test_stuffing();
        pulse_t e, o;
        logic   got;
        int     eop0, serr0;
        eop0  = eop_count;
        serr0 = serr_count;
        send_sync(8, 8, 1'b0);
        for (int i = 0; i < 8; i++) send_payload(1'b1, 8, -1);
        send_eop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(o, got);
            compared++;
            if (!got || o.val !== e.val) begin
                mismatched++;
                $display("[TB] FAIL stuff_bit: got %b (present=%0b), expected %b", o.val, got, e.val);
            end
        end
        compared++;
        if (obs_rd != obs_q.size()) begin
            mismatched++;
            $display("[TB] FAIL stuff_extra: got %0d extra pulses, expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
        compared++;
        if (eop_count - eop0 != 1 || serr_count != serr0) begin
            mismatched++;
            $display("[TB] FAIL stuff_eop: got eop=%0d err=%0d, expected 1/0", eop_count - eop0, serr_count - serr0);
        end
    endtask

    task automatic test_back_to_back();
        pulse_t e, o;
        logic   got;
        int     eop0;
        eop0 = eop_count;
        send_sync(8, 8, 1'b0);
        send_eop();
        send_sync(8, 8, 1'b0);
        send_eop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(o, got);
            compared++;
            if (!got || o.val !== e.val) begin
                mismatched++;
                $display("[TB] FAIL b2b_bit: got %b (present=%0b), expected %b", o.val, got, e.val);
            end
        end
        compared++;
        if (obs_rd != obs_q.size() || eop_count - eop0 != 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_end: got extra=%0d eop=%0d, expected 0/2", obs_q.size() - obs_rd, eop_count - eop0);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_jitter();
        pulse_t e, o;
        logic   got;
        int     eop0;
        for (int p = 0; p < 2; p++) begin
            eop0 = eop_count;
            send_sync(p == 0 ? 9 : 10, p == 0 ? 7 : 6, 1'b0);
            send_eop();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                next_obs(o, got);
                compared++;
                if (!got || o.val !== e.val) begin
                    mismatched++;
                    $display("[TB] FAIL jitter_bit p%0d: got %b (present=%0b), expected %b", p, o.val, got, e.val);
                end
            end
            compared++;
            if (obs_rd != obs_q.size() || eop_count - eop0 != 1) begin
                mismatched++;
                $display("[TB] FAIL jitter_end p%0d: got extra=%0d eop=%0d, expected 0/1",
                         p, obs_q.size() - obs_rd, eop_count - eop0);
                obs_rd = obs_q.size();
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        pulse_t e, o;
        logic   got;
        int     eop0, serr0;
        eop0  = eop_count;
        serr0 = serr_count;
        for (int i = 0; i < 4; i++) send_payload(1'b0, 8, -1);
        cur_dp = ~cur_dp;
        drive_line(cur_dp, ~cur_dp, 3);
        #1;
        n_rst = 1'b0;
        #1;
        compared++;
        if ({d_orig, shift_enable, eop, stuff_err} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs: got %b, expected 1000", {d_orig, shift_enable, eop, stuff_err});
        end
        cur_dp  = 1'b1;
        tb_ones = 0;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(o, got);
            compared++;
            if (!got || o.val !== e.val) begin
                mismatched++;
                $display("[TB] FAIL midreset_bit: got %b (present=%0b), expected %b", o.val, got, e.val);
            end
        end
        compared++;
        if (obs_rd != obs_q.size() || eop_count != eop0 || serr_count != serr0) begin
            mismatched++;
            $display("[TB] FAIL midreset_stray: got se=%0d eop=%0d err=%0d, expected 0/0/0",
                     obs_q.size() - obs_rd, eop_count - eop0, serr_count - serr0);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_stuff_error();
        pulse_t e, o;
        logic   got;
        int     eop0, serr0, exp_eop, exp_serr;
        pulse_t one;
        eop0  = eop_count;
        serr0 = serr_count;
        one.val = 1'b1;
        one.at  = -1;
        send_sync(8, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
`ifdef USB_RX_STUFF_ERR_EN
            if (i < 5) exp_q.push_back(one);
`else
            if (i != 5) exp_q.push_back(one);
`endif
            send_bit(1'b1, 8);
        end
        send_eop();
        send_sync(8, 8, 1'b0);
        send_eop();
`ifdef USB_RX_STUFF_ERR_EN
        exp_eop  = 1;
        exp_serr = 1;
`else
        exp_eop  = 2;
        exp_serr = 0;
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(o, got);
            compared++;
            if (!got || o.val !== e.val) begin
                mismatched++;
                $display("[TB] FAIL stufferr_bit: got %b (present=%0b), expected %b", o.val, got, e.val);
            end
        end
        compared++;
        if (obs_rd != obs_q.size()) begin
            mismatched++;
            $display("[TB] FAIL stufferr_extra: got %0d extra pulses, expected 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
        compared++;
        if (serr_count - serr0 != exp_serr) begin
            mismatched++;
            $display("[TB] FAIL stufferr_flag: got %0d pulses, expected %0d", serr_count - serr0, exp_serr);
        end
        compared++;
        if (eop_count - eop0 != exp_eop) begin
            mismatched++;
            $display("[TB] FAIL stufferr_eop: got %0d pulses, expected %0d", eop_count - eop0, exp_eop);
        end
    endtask

    initial begin
        n_rst   = 1'b0;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        @(negedge clk);
        test_reset();
        test_sync();
        test_stuffing();
        test_back_to_back();
        test_jitter();
        test_reset_mid_packet();
        test_stuff_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_decoder.md
# usb_rx_bit_decoder

Front-end bit recovery stage of the USB full-speed receive path, placed directly upstream of `USB_rx`. It samples the `d_plus`/`d_minus` pair at 8× the bit rate (96 MHz clock, 12 Mb/s line) and recovers bit timing from line transitions. It then NRZI-decodes, removes stuffed bits, and hands the packet layer one decoded bit per `shift_enable` pulse plus an end-of-packet strobe.

## Interface
- `SAMPLE_PT`, default 3: timer count at which a bit is sampled, valid range 2..5.
- `clk`  in  1  system clock, 96 MHz, rising-edge active.
- `n_rst`  in  1  asynchronous active-low reset.
- `d_plus`  in  1  raw USB D+ line, asynchronous to `clk`.
- `d_minus`  in  1  raw USB D− line, asynchronous to `clk`.
- `d_orig`  out  1  decoded (NRZI-removed, unstuffed) data bit, valid while `shift_enable`=1.
- `shift_enable`  out  1  one-cycle pulse: `d_orig` holds a new payload bit.
- `eop`  out  1  one-cycle pulse: SE0 was sampled at a bit sample point.
- `stuff_err`  out  1  one-cycle pulse on a bit-stuff violation; tied 0 when the feature is compiled out.

## Operation
- **Synchronizers:** two flops per line, giving `dp_s` and `dm_s`. Reset values are `dp_s`=1 and `dm_s`=0 (idle J state).
- **Edge detect:** `edge = dp_s ^ dp_s_prev`. `dp_s_prev` resets to 1.
- **State machine** (`IDLE`, `ACTIVE`, `EOP_WAIT`):
  - `IDLE` → `ACTIVE` on the first `edge`.
  - `ACTIVE` → `EOP_WAIT` when SE0 (`dp_s`=0, `dm_s`=0) is present at a sample point.
  - `EOP_WAIT` → `IDLE` when J (`dp_s`=1, `dm_s`=0) is present at a sample point.
- **Bit timer:** 3-bit counter.
  - Held at 0 in `IDLE`.
  - In `ACTIVE` and `EOP_WAIT`: cleared to 0 on any `edge`, otherwise increments and wraps 7→0.
  - A sample point is `count == SAMPLE_PT` with no `edge` in the same cycle.
- **NRZI decode at a sample point:** `bit = ~(dp_s ^ last_dp)`, then `last_dp <= dp_s`. `last_dp` resets to 1 and reloads to 1 on entry to `IDLE`.
- **Unstuffing:** 3-bit `ones` counter, reset 0.
  - A decoded 1 increments it; a decoded 0 clears it.
  - When `ones == 6`, the next sampled bit is a stuff bit. It produces no `shift_enable`, and `ones` is cleared.
  - If that stuff bit decodes as 1, it is a stuff violation; see Configuration.
- **Output at a sample point in `ACTIVE` (not SE0, not a stuff bit):** `shift_enable`=1 and `d_orig`=`bit`. All three outputs are registered.
- **SE0 at a sample point:**
  - Pulse `eop` once. No `shift_enable`.
  - Clear `ones`.
  - SE0 sampled again in `EOP_WAIT` does not re-pulse `eop`.
- **Reset at any time:** all state returns to reset values, and the state machine enters `IDLE`. This includes a reset mid-packet.
- **Outputs out of reset:** `d_orig`=1, `shift_enable`=0, `eop`=0, `stuff_err`=0.

## Timing
- A pin transition set up before rising edge k appears on `dp_s` after edge k+1.
- `edge` is seen combinationally in cycle k+1..k+2, and the counter is 0 after edge k+2.
- With `SAMPLE_PT`=3, `shift_enable` and `eop` go high after edge k+6 for one cycle.
- Without further edges, subsequent pulses follow every 8 cycles.
- An edge arriving at any counter value resynchronizes the timer immediately. Jitter of ±2 clocks per bit never drops or duplicates a bit.
- An edge coincident with `count == SAMPLE_PT` suppresses that sample. The timer restarts, and the bit is sampled `SAMPLE_PT` cycles later.
- `stuff_err` is asserted in the same cycle a `shift_enable` would have been.

## Configuration
- Macro `USB_RX_STUFF_ERR_EN`.
- **Defined:**
  - A stuff bit decoding as 1 pulses `stuff_err` for one cycle.
  - The state machine returns to `EOP_WAIT`, so decoding stops until J is seen after SE0 or idle.
- **Undefined:**
  - `stuff_err` is tied to 0.
  - A stuff bit decoding as 1 is silently discarded, identically to a valid stuff bit.

## Test plan
- **Idle after reset:** hold J (1/0) for 64 cycles → `shift_enable`, `eop` and `stuff_err` stay 0; `d_orig`=1.
- **SYNC:**
  - Stimulus: from J, drive the NRZI form of SYNC byte 0x80, LSB first, at 8 clocks/bit.
  - Required: exactly 8 `shift_enable` pulses with `d_orig` = 0,0,0,0,0,0,0,1.
  - Required: pulses 8 cycles apart, the first one 6 cycles after the first pin edge.
- **Stuffing:** after SYNC, send 0xFF data with a stuffed 0 after six 1s → 8 pulses, all with `d_orig`=1; the stuff bit produces no pulse.
- **EOP:**
  - Stimulus: SE0 for 16 cycles, then J.
  - Required: exactly one `eop` pulse and no `shift_enable`.
  - Required: returns to `IDLE`, and a following SYNC decodes correctly.
- **Jitter:** repeat SYNC with alternate bits stretched to 9 clocks and shrunk to 7 → identical decoded bit sequence.
- **Reset mid-packet / stuff error:**
  - Reset mid-packet: assert `n_rst` mid-byte → outputs are at reset values immediately and no stray pulse follows.
  - Stuff error, with `USB_RX_STUFF_ERR_EN` defined: send seven decoded 1s → one `stuff_err` pulse and no further `shift_enable` until SE0→J.
  - Stuff error, with the macro undefined: the same stimulus gives `stuff_err`=0 and 6 pulses.
